// File: rtl/perceptron_arbiter.sv
// Two-requester perceptron classifier: grant one job, accumulate 16 weighted feature bits, compare with bias.
// Define PERCEPTRON_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module perceptron_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       ack,
    input  logic       wt_we,
    input  logic [4:0] wt_addr,
    input  logic [7:0] wt_data,
    output logic       gnt0,
    output logic       gnt1,
    output logic       out_valid,
    output logic       out_class,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  weight   [16];
    logic [7:0]  bias;
    logic [7:0]  job_w    [16];
    logic [7:0]  job_bias;
    logic [15:0] operand;
    logic [7:0]  sum;
    logic [3:0]  idx;
    logic        pick1;
    logic        capture;
    logic [8:0]  acc_ext;
    logic [7:0]  sum_next;
    logic [8:0]  decide_ext;
    logic        decide_class;

    assign capture = (state_q == IDLE) && (req0 || req1);
    assign busy    = (state_q != IDLE);

`ifdef PERCEPTRON_ARB_RR_EN
    logic last_winner;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_winner <= 1'b1;
        else if (capture)
            last_winner <= pick1;
    end

    assign pick1 = req1 && (!req0 || !last_winner);
`else
    assign pick1 = req1 && !req0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = ACCUM;
            ACCUM:   if (idx == 4'd15) state_d = DECIDE;
            DECIDE:  state_d = RESP;
            RESP:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        acc_ext      = {1'b0, sum} + {1'b0, job_w[idx]};
        sum_next     = sum;
        if (operand[idx])
            sum_next = acc_ext[8] ? 8'hFF : acc_ext[7:0];
        decide_ext   = {1'b0, sum} + {1'b0, job_bias};
        decide_class = (decide_ext > 9'd254);
    end

    // The job runs on a snapshot so a write committing on the capture edge cannot leak into it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                weight[i] <= 8'h80;
                job_w[i]  <= 8'h80;
            end
            bias <= '0;
        end else if (state_q == IDLE) begin
            if (capture) begin
                for (int unsigned i = 0; i < 16; i++)
                    job_w[i] <= weight[i];
            end
            if (wt_we) begin
                if (!wt_addr[4])
                    weight[wt_addr[3:0]] <= wt_data;
                else if (wt_addr == 5'd16)
                    bias <= wt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_bias  <= '0;
            operand   <= '0;
            sum       <= '0;
            idx       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            out_valid <= 1'b0;
            out_class <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        job_bias <= bias;
                        operand  <= pick1 ? {b1, a1} : {b0, a0};
                        sum      <= '0;
                        idx      <= '0;
                        gnt0     <= !pick1;
                        gnt1     <= pick1;
                    end
                end
                ACCUM: begin
                    sum <= sum_next;
                    idx <= idx + 4'd1;
                end
                DECIDE: begin
                    out_class <= decide_class;
                    out_valid <= 1'b1;
                end
                RESP: begin
                    if (ack) begin
                        out_valid <= 1'b0;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
